// File: rtl/torus_pipe.sv
// 2-D torus link fabric: every directed router-to-router link is buffered by its
// own small FIFO with valid/ready on both sides and a per-link enable for power gating.
module torus_pipe #(
  parameter int H_SIZE     = 3,
  parameter int V_SIZE     = 2,
  parameter int DATA_WIDTH = 37,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [H_SIZE*V_SIZE*4*DATA_WIDTH-1:0] tx_data,
  input  logic [H_SIZE*V_SIZE*4-1:0]            tx_valid,
  output logic [H_SIZE*V_SIZE*4-1:0]            tx_ready,
  output logic [H_SIZE*V_SIZE*4*DATA_WIDTH-1:0] rx_data,
  output logic [H_SIZE*V_SIZE*4-1:0]            rx_valid,
  input  logic [H_SIZE*V_SIZE*4-1:0]            rx_ready,
  input  logic [H_SIZE*V_SIZE*4-1:0]            link_en,
  output logic [H_SIZE*V_SIZE*4-1:0]            link_busy
);

  localparam int NODES_NUM = H_SIZE * V_SIZE;
  localparam int LINKS     = NODES_NUM * 4;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

  // Receiving slot (m*4+q) for the flit leaving node n on port p (east, south, west, north).
  function automatic int dst_link(input int l);
    int n, p, r, c, m, q;
    n = l / 4;
    p = l % 4;
    r = n / H_SIZE;
    c = n % H_SIZE;
    m = 0;
    q = 0;
    case (p)
      0: begin m = r * H_SIZE + (c + 1) % H_SIZE;          q = 2; end
      1: begin m = (n + H_SIZE) % NODES_NUM;               q = 3; end
      2: begin m = r * H_SIZE + (c + H_SIZE - 1) % H_SIZE; q = 0; end
      default: begin m = (n + NODES_NUM - H_SIZE) % NODES_NUM; q = 1; end
    endcase
    return m * 4 + q;
  endfunction

  for (genvar l = 0; l < LINKS; l++) begin : g_link
    localparam int DST = dst_link(l);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);

    // tx_ready depends only on stored count and link_en, never on rx_ready,
    // so a full buffer refuses a push even in a cycle where it drains.
    assign tx_ready[l]  = link_en[l] & ~full;
    assign push         = tx_valid[l] & tx_ready[l];
    assign pop          = ~empty & rx_ready[DST];
    assign link_busy[l] = ~empty;

    assign rx_valid[DST]                             = ~empty;
    assign rx_data[DST*DATA_WIDTH +: DATA_WIDTH]     = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        // NOTE: storage is cleared as well so rx_data reads zero after reset; this
        // makes the buffer flops rather than RAM, which is fine at these depths.
        for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        // NOTE: non-blocking throughout, so every test below sees the pre-edge state.
        if (push) begin
          mem[wr_ptr] <= tx_data[l*DATA_WIDTH +: DATA_WIDTH];
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_torus_pipe.sv
// Self-checking bench for torus_pipe: routing table, hand-written corner sequences,
// and randomized traffic compared every cycle against a per-link queue model.
module tb_torus_pipe;

  localparam int H     = 3;
  localparam int V     = 2;
  localparam int DW    = 37;
  localparam int DEPTH = 2;
  localparam int NN    = H * V;
  localparam int LINKS = NN * 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [LINKS*DW-1:0]   tx_data;
  logic [LINKS-1:0]      tx_valid;
  logic [LINKS-1:0]      tx_ready;
  logic [LINKS*DW-1:0]   rx_data;
  logic [LINKS-1:0]      rx_valid;
  logic [LINKS-1:0]      rx_ready;
  logic [LINKS-1:0]      link_en;
  logic [LINKS-1:0]      link_busy;

  int checks   = 0;
  int failures = 0;

  // Reference: one queue of flits per source link.
  logic [DW-1:0] mq [LINKS][$];

  torus_pipe #(.H_SIZE(H), .V_SIZE(V), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .link_en(link_en), .link_busy(link_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dst(input int l);
    int n, p, r, c;
    n = l / 4; p = l % 4; r = n / H; c = n % H;
    case (p)
      0: return (r * H + (c + 1) % H) * 4 + 2;
      1: return ((n + H) % NN) * 4 + 3;
      2: return (r * H + (c + H - 1) % H) * 4 + 0;
      default: return ((n + NN - H) % NN) * 4 + 1;
    endcase
  endfunction

  function automatic logic [DW-1:0] rx_slice(input int d);
    return rx_data[d*DW +: DW];
  endfunction

  task automatic compare_all();
    logic [LINKS-1:0] e_rdy, e_busy, e_rxv;
    e_rdy = '0; e_busy = '0; e_rxv = '0;
    for (int l = 0; l < LINKS; l++) begin
      e_rdy[l]      = link_en[l] && (mq[l].size() < DEPTH);
      e_busy[l]     = mq[l].size() > 0;
      e_rxv[dst(l)] = mq[l].size() > 0;
    end
    check("tx_ready", 64'(tx_ready), 64'(e_rdy));
    check("link_busy", 64'(link_busy), 64'(e_busy));
    check("rx_valid", 64'(rx_valid), 64'(e_rxv));
    for (int l = 0; l < LINKS; l++)
      if (mq[l].size() > 0) check("rx_data", 64'(rx_slice(dst(l))), 64'(mq[l][0]));
  endtask

  // Advance the model by one clock edge using the inputs held at that edge.
  task automatic model_edge();
    bit do_push [LINKS];
    bit do_pop  [LINKS];
    if (!rst_n) begin
      for (int l = 0; l < LINKS; l++) mq[l].delete();
    end else begin
      for (int l = 0; l < LINKS; l++) begin
        do_pop[l]  = (mq[l].size() > 0) && rx_ready[dst(l)];
        do_push[l] = tx_valid[l] && link_en[l] && (mq[l].size() < DEPTH);
      end
      for (int l = 0; l < LINKS; l++) begin
        if (do_pop[l]) void'(mq[l].pop_front());
        if (do_push[l]) mq[l].push_back(tx_data[l*DW +: DW]);
      end
    end
  endtask

  task automatic step();
    #1 compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_flit(input int l, input logic [DW-1:0] d);
    tx_data[l*DW +: DW] = d;
  endtask

  typedef struct {
    int            src_node;
    int            src_port;
    logic [DW-1:0] data;
    int            dst_node;
    int            dst_port;
  } route_vec_t;

  initial begin
    route_vec_t rt [6];
    int         d;
    rt[0] = '{2, 0, 37'h1A5, 0, 2};
    rt[1] = '{0, 2, 37'h0B7, 2, 0};
    rt[2] = '{4, 1, 37'h1C3, 1, 3};
    rt[3] = '{0, 3, 37'h0D9, 3, 1};
    rt[4] = '{5, 0, 37'h155, 3, 2};
    rt[5] = '{3, 3, 37'h0AA, 0, 1};

    rst_n = 1'b0; tx_data = '0; tx_valid = '0; rx_ready = '1; link_en = '1;
    @(posedge clk); model_edge(); #1;

    // Reset with links enabled, then disabled.
    step();
    rst_n = 1'b1;
    #1;
    check("rst_rx_valid", 64'(rx_valid), 64'd0);
    check("rst_busy", 64'(link_busy), 64'd0);
    check("rst_tx_ready", 64'(tx_ready), 64'(24'hFFFFFF));
    check("rst_rx_data_zero", 64'(rx_data == '0), 64'd1);
    link_en = '0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1 check("rst_tx_ready_dis", 64'(tx_ready), 64'd0);
    link_en = '1;

    // Wrap-around routing, one flit at a time.
    for (int i = 0; i < 6; i++) begin
      tx_valid = '0;
      tx_valid[rt[i].src_node*4 + rt[i].src_port] = 1'b1;
      set_flit(rt[i].src_node*4 + rt[i].src_port, rt[i].data);
      step();
      tx_valid = '0;
      d = rt[i].dst_node*4 + rt[i].dst_port;
      #1;
      check("route_valid", 64'(rx_valid), 64'(1) << d);
      check("route_data", 64'(rx_slice(d)), 64'(rt[i].data));
      step();
    end

    // Backpressure on node0 east -> node1 west.
    rx_ready = '1; rx_ready[6] = 1'b0;
    tx_valid[0] = 1'b1;
    set_flit(0, 37'h1); step();
    set_flit(0, 37'h2); step();
    set_flit(0, 37'h3);
    #1 check("bp_full_not_ready", 64'(tx_ready[0]), 64'd0);
    step(); step();
    rx_ready[6] = 1'b1;
    #1 check("bp_head1", 64'(rx_slice(6)), 64'h1);
    step();
    check("bp_ready_after_pop", 64'(tx_ready[0]), 64'd1);
    check("bp_head2", 64'(rx_slice(6)), 64'h2);
    step();
    tx_valid[0] = 1'b0;
    #1 check("bp_head3", 64'(rx_slice(6)), 64'h3);
    step();
    #1 check("bp_drained", 64'(rx_valid[6]), 64'd0);

    // Streaming node1 south -> node4 north, no bubbles.
    tx_valid[5] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_flit(5, DW'(i));
      step();
      check("stream_valid", 64'(rx_valid[19]), 64'd1);
      check("stream_data", 64'(rx_slice(19)), 64'(i));
      check("stream_ready", 64'(tx_ready[5]), 64'd1);
    end
    tx_valid[5] = 1'b0;
    step(); step();

    // Link disable on node2 west -> node1 east while another link keeps streaming.
    rx_ready[4] = 1'b0;
    tx_valid[10] = 1'b1;
    set_flit(10, 37'h0A1); step();
    set_flit(10, 37'h0A2); step();
    link_en[10] = 1'b0; rx_ready = '1;
    tx_valid[0] = 1'b1; set_flit(0, 37'h777);
    #1 check("dis_tx_ready", 64'(tx_ready[10]), 64'd0);
    check("dis_other_ready", 64'(tx_ready[0]), 64'd1);
    check("dis_head1", 64'(rx_slice(4)), 64'h0A1);
    step();
    check("dis_busy_mid", 64'(link_busy[10]), 64'd1);
    check("dis_head2", 64'(rx_slice(4)), 64'h0A2);
    step();
    check("dis_busy_fall", 64'(link_busy[10]), 64'd0);
    check("dis_rx_empty", 64'(rx_valid[4]), 64'd0);
    tx_valid = '0; link_en = '1;
    step(); step();

    // Mid-transfer reset with every buffer full.
    rx_ready = '0; tx_valid = '1;
    for (int l = 0; l < LINKS; l++) set_flit(l, DW'({$urandom(), $urandom()}));
    step(); step(); step();
    check("full_busy", 64'(link_busy), 64'(24'hFFFFFF));
    check("full_not_ready", 64'(tx_ready), 64'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; tx_valid = '0; rx_ready = '1;
    #1 check("mid_rst_rx_valid", 64'(rx_valid), 64'd0);
    check("mid_rst_busy", 64'(link_busy), 64'd0);
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int l = 0; l < LINKS; l++) begin
        tx_valid[l] = ($urandom_range(0, 3) != 0);
        rx_ready[l] = ($urandom_range(0, 2) != 0);
        link_en[l]  = ($urandom_range(0, 9) != 0);
        set_flit(l, DW'({$urandom(), $urandom()}));
      end
      step();
    end
    rst_n = 1'b1; tx_valid = '0; rx_ready = '1; link_en = '1;
    for (int i = 0; i < 4; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/torus_pipe.md
# torus_pipe

Registered successor to the combinational torus connector. It links `H_SIZE × V_SIZE` four-port router nodes into a 2-D torus with wrap-around in both dimensions. Every directed link carries a valid/ready handshake and passes through its own `FIFO_DEPTH`-entry buffer, which breaks all long wrap-around wires at a register. Per-link enable and busy status let power-gating control isolate and drain individual links.

## Interface
- `H_SIZE`, 3, nodes per row (≥2)
- `V_SIZE`, 2, rows (≥2)
- `DATA_WIDTH`, 37, flit payload bits
- `FIFO_DEPTH`, 2, entries per link buffer (power of two, ≥2)
- `NODES_NUM` (localparam), `H_SIZE*V_SIZE`
- Links are indexed `L = n*4+p`, where `n` is the node and `p` is the port. Data buses use slice `[L*DATA_WIDTH +: DATA_WIDTH]`.
- Ports: 0 = east, 1 = south, 2 = west, 3 = north.
- Reset: one clock; reset is synchronous and active-low.

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `tx_data`  in  `NODES_NUM*4*DATA_WIDTH`  flit from node `n`, output port `p`
- `tx_valid`  in  `NODES_NUM*4`  flit present on `tx_data` slice `L`
- `tx_ready`  out  `NODES_NUM*4`  link `L` accepts a flit this cycle
- `rx_data`  out  `NODES_NUM*4*DATA_WIDTH`  flit delivered to node `m`, input port `q`
- `rx_valid`  out  `NODES_NUM*4`  `rx_data` slice valid
- `rx_ready`  in  `NODES_NUM*4`  node accepts delivered flit
- `link_en`  in  `NODES_NUM*4`  enable, indexed by source link
- `link_busy`  out  `NODES_NUM*4`  source link's buffer non-empty

## Operation
- Node coordinates: `r = n / H_SIZE`, `c = n % H_SIZE`.
- Source `(n,p)` maps to destination `(m,q)` as follows:
  - p=0 → `m = r*H_SIZE + (c+1)%H_SIZE`, q=2
  - p=2 → `m = r*H_SIZE + (c+H_SIZE-1)%H_SIZE`, q=0
  - p=1 → `m = (n+H_SIZE)%NODES_NUM`, q=3
  - p=3 → `m = (n+NODES_NUM-H_SIZE)%NODES_NUM`, q=1
- The mapping is a bijection: every rx slot is driven by exactly one FIFO.
- One FIFO per source link holds write pointer, read pointer and count.
  - Pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo `FIFO_DEPTH`.
  - Count is `$clog2(FIFO_DEPTH+1)` bits.
- Push: occurs when `tx_valid[L] & tx_ready[L]`.
- `tx_ready[L] = link_en[L] & (count != FIFO_DEPTH)`.
  - It is derived only from registered state and `link_en`.
  - There is no path from `rx_ready` to `tx_ready`.
  - A full FIFO does not accept a push in a cycle where it pops.
- Pop: occurs when `rx_valid[dst] & rx_ready[dst]`.
  - `rx_valid[dst] = (count != 0)`.
  - `rx_data[dst]` = head entry.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
- Flits are delivered in order per link. No flit is dropped or duplicated.
- `link_en` low:
  - `tx_ready` forced to 0.
  - Buffered flits still drain to the destination.
  - Nothing is flushed.
- `link_busy[L] = (count != 0)`.
- Storage entries reset to 0, so `rx_data` reads 0 while empty after reset. Otherwise `rx_data` is don't-care when `rx_valid` is 0.

## Timing
- Reset (`rst_n` low at an edge), effective the following cycle:
  - all counts 0, pointers 0, storage 0
  - `rx_valid` = 0, `link_busy` = 0, `rx_data` = 0
  - `tx_ready` = `link_en`
- Reset mid-transfer discards all buffered flits. Pushes in the reset cycle are ignored.
- Latency: a push at edge t gives `rx_valid` high in cycle t+1.
- Throughput: one flit per cycle per link when `rx_ready` is held 1. No bubbles at `FIFO_DEPTH` ≥ 2.
- Backpressure: with `rx_ready` = 0, `tx_ready` falls the cycle after the `FIFO_DEPTH`-th push.
- After the first pop, `tx_ready` rises one cycle later.
- `link_busy` falls in the cycle after the last pop.

## Test plan
- Reset: drive `rst_n`=0 one edge with `link_en`=all 1s → all `rx_valid`=0, `link_busy`=0, `tx_ready`=all 1s. Then repeat with `link_en`=0 → `tx_ready`=0.
- Wrap-around routing (H=3, V=2), one flit per case, `rx_ready` held 1:
  - node2.p0 sends 0x1A5 → node0.p2 `rx_valid` next cycle, data 0x1A5.
  - node0.p2 → node2.p0.
  - node4.p1 → node1.p3.
  - node0.p3 → node3.p1.
  - No other `rx_valid` asserts.
- Backpressure (DEPTH=2): node1.p2 `rx_ready`=0; node0.p0 offers 0x1, 0x2, 0x3 back-to-back → `tx_ready` low after the 2nd push.
  - Raise `rx_ready` → outputs 0x1, 0x2 on consecutive cycles.
  - 0x3 is accepted one cycle after the first pop and delivered in order.
- Streaming: 16 flits 0x00–0x0F, `tx_valid`/`rx_ready` held 1 → one delivery per cycle, each appearing 1 cycle after push, no gaps.
- Link disable: 2 flits buffered, then `link_en[L]`=0 with `rx_ready`=1 → `tx_ready[L]`=0 the same cycle.
  - Both flits still delivered.
  - `link_busy[L]` falls the cycle after the 2nd pop.
  - Other links unaffected.
- Mid-transfer reset: all FIFOs full, `rst_n`=0 one edge → all `rx_valid`=0, `link_busy`=0 next cycle. Old flits never appear afterwards.
